// File: rtl/vl_aca_pkg.sv
// Shared types and default sizing for the accuracy-configurable (speculative) adder.
package vl_aca_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_WIN   = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        FIX  = 2'd2
    } aca_state_t;

endpackage

// File: rtl/aca_spec_sum.sv
// Speculative adder: each carry is derived from at most WIN lower operand bits,
// with a carry of zero assumed to enter that window.
module aca_spec_sum
    import vl_aca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WIN   = DEF_WIN
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] carry_s;

    assign carry_s[0] = 1'b0;

    // A window of LEN bits overflows exactly when a_win + b_win >= 2**LEN,
    // i.e. when a_win > ~b_win, which avoids carrying an unused partial sum.
    for (genvar i = 1; i <= WIDTH; i++) begin : g_win
        localparam int LO  = (i > WIN) ? (i - WIN) : 0;
        assign carry_s[i] = (a[i-1:LO] > ~b[i-1:LO]);
    end

    assign sum = {carry_s[WIDTH], a ^ b ^ carry_s[WIDTH-1:0]};

endmodule

// File: rtl/vl_aca_adder.sv
// Speculative adder with valid/ready handshake, miss detection and a saturating miss counter.
// Define ACA_ERR_CORRECT_EN to re-add missed operands exactly in an extra FIX cycle.
module vl_aca_adder
    import vl_aca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WIN   = DEF_WIN,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH:0]   result_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    input  logic             clr_cnt_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    aca_state_t       state_r;
    aca_state_t       state_nxt_s;
    aca_state_t       accept_tgt_s;
    logic             accept_s;
    logic             miss_s;
    logic [WIDTH-1:0] sum_a_s;
    logic [WIDTH-1:0] sum_b_s;
    logic [WIDTH:0]   spec_s;
    logic [WIDTH:0]   exact_s;
    logic [WIDTH:0]   result_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;

`ifdef ACA_ERR_CORRECT_EN
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;

    // Capture missed operands so FIX can re-add them exactly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_a_r <= {WIDTH{1'b0}};
            op_b_r <= {WIDTH{1'b0}};
        end else if (accept_s && miss_s) begin
            op_a_r <= add1_i;
            op_b_r <= add2_i;
        end else begin
            op_a_r <= op_a_r;
            op_b_r <= op_b_r;
        end
    end

    // FIX never accepts, so the adders are free to work on the captured pair.
    assign sum_a_s      = (state_r == FIX) ? op_a_r : add1_i;
    assign sum_b_s      = (state_r == FIX) ? op_b_r : add2_i;
    assign accept_tgt_s = miss_s ? FIX : HOLD;
`else
    assign sum_a_s      = add1_i;
    assign sum_b_s      = add2_i;
    assign accept_tgt_s = HOLD;
`endif

    aca_spec_sum #(
        .WIDTH (WIDTH),
        .WIN   (WIN)
    ) u_spec_sum (
        .a   (sum_a_s),
        .b   (sum_b_s),
        .sum (spec_s)
    );

    assign exact_s  = {1'b0, sum_a_s} + {1'b0, sum_b_s};
    assign miss_s   = (spec_s != exact_s);
    assign accept_s = valid_i && ready_o;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = accept_tgt_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (!ready_i) begin
                    state_nxt_s = HOLD;
                end else if (accept_s) begin
                    state_nxt_s = accept_tgt_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
`ifdef ACA_ERR_CORRECT_EN
            FIX: begin
                state_nxt_s = HOLD;
            end
`endif
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake outputs; ready_o is forced low while reset is held.
    always_comb begin
        ready_o = 1'b0;
        valid_o = (state_r == HOLD);
        if (rst_i) begin
            ready_o = 1'b0;
        end else begin
            ready_o = (state_r == IDLE) || ((state_r == HOLD) && ready_i);
        end
    end

    // Result register: speculative sum on accept, exact sum when leaving FIX.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_r <= {(WIDTH+1){1'b0}};
            err_r    <= 1'b0;
        end else if (accept_s) begin
            result_r <= spec_s;
            err_r    <= miss_s;
`ifdef ACA_ERR_CORRECT_EN
        end else if (state_r == FIX) begin
            result_r <= exact_s;
            err_r    <= 1'b1;
`endif
        end else begin
            result_r <= result_r;
            err_r    <= err_r;
        end
    end

    // Saturating miss counter; a clear beats a coincident increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_cnt_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && miss_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign result_o  = result_r;
    assign err_o     = err_r;
    assign err_cnt_o = cnt_r;

endmodule

// File: tb/tb_vl_aca_adder.sv
// Bench for vl_aca_adder: transaction-level model plus directed literal vectors.
// Honours ACA_ERR_CORRECT_EN the same way the design does.
module tb_vl_aca_adder;

    localparam int WN = 8;
`ifdef ACA_ERR_CORRECT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        clr_cnt_i = 1'b0;
    logic [31:0] add1 = 32'd0;
    logic [31:0] add2 = 32'd0;
    logic        ready_o, valid_o, err_o;
    logic [32:0] result_o;
    logic [15:0] err_cnt_o;
    logic        s_ready_o, s_valid_o, s_err_o;
    logic [32:0] s_result_o;
    logic [1:0]  s_cnt_o;
    logic        f_valid_i = 1'b0;
    logic        f_ready_i = 1'b1;
    logic        f_clr_i = 1'b0;
    logic [31:0] f_a = 32'd0;
    logic [31:0] f_b = 32'd0;
    logic        f_ready_o, f_valid_o, f_err_o;
    logic [32:0] f_result_o;
    logic [15:0] f_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    logic        m_busy = 1'b0;
    int          m_delay = 0;
    logic [32:0] m_res = 33'd0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;
    int          sm_cnt = 0;
    logic        fm_busy = 1'b0;
    logic [32:0] fm_res = 33'd0;
    logic        fm_err = 1'b0;
    int          fm_cnt = 0;
    logic        mm_acc;
    logic [32:0] mm_sp, mm_ex;

    always #5 clk = ~clk;

    vl_aca_adder u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .add1_i(add1), .add2_i(add2), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .err_o(err_o), .err_cnt_o(err_cnt_o), .clr_cnt_i(clr_cnt_i)
    );

    vl_aca_adder #(.WIDTH(32), .WIN(8), .CNT_W(2)) u_small (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(s_ready_o),
        .add1_i(add1), .add2_i(add2), .valid_o(s_valid_o), .ready_i(ready_i),
        .result_o(s_result_o), .err_o(s_err_o), .err_cnt_o(s_cnt_o), .clr_cnt_i(clr_cnt_i)
    );

    vl_aca_adder #(.WIDTH(32), .WIN(32), .CNT_W(16)) u_full (
        .clk_i(clk), .rst_i(rst), .valid_i(f_valid_i), .ready_o(f_ready_o),
        .add1_i(f_a), .add2_i(f_b), .valid_o(f_valid_o), .ready_i(f_ready_i),
        .result_o(f_result_o), .err_o(f_err_o), .err_cnt_o(f_cnt_o), .clr_cnt_i(f_clr_i)
    );

    // Carry into bit i comes from bits max(0,i-win)..i-1 only, window entered with carry 0.
    function automatic logic [32:0] model_spec(input logic [31:0] a, input logic [31:0] b, input int win);
        logic [32:0]     s;
        int              lo;
        int              len;
        longint unsigned wa, wb, c, mask;
        s = 33'd0;
        for (int i = 0; i <= 32; i++) begin
            lo   = (i > win) ? (i - win) : 0;
            len  = i - lo;
            mask = (64'd1 << len) - 64'd1;
            wa   = ({32'd0, a} >> lo) & mask;
            wb   = ({32'd0, b} >> lo) & mask;
            c    = ((wa + wb) >> len) & 64'd1;
            if (i < 32) s[i] = a[i] ^ b[i] ^ c[0];
            else        s[32] = c[0];
        end
        return s;
    endfunction

    function automatic logic [32:0] model_exact(input logic [31:0] a, input logic [31:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic model_ready();
        return !rst && (!m_busy || (m_delay == 0 && ready_i));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] b, input logic clr,
                        output int lat, output logic [32:0] res, output logic e);
        int guard;
        tick();
        valid_i = 1'b1; add1 = a; add2 = b; clr_cnt_i = clr;
        guard = 0;
        @(negedge clk);
        while (!ready_o && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 20) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: ready_o stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0; clr_cnt_i = 1'b0;
        lat = 0;
        while (lat < 6) begin
            lat++;
            @(negedge clk);
            if (valid_o) break;
        end
        res = result_o;
        e   = err_o;
    endtask

    // Transaction model, stepped on the same edges as the design.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 1'b0; m_delay = 0; m_res = 33'd0; m_err = 1'b0; m_cnt = 0; sm_cnt = 0;
            fm_busy = 1'b0; fm_res = 33'd0; fm_err = 1'b0; fm_cnt = 0;
        end else begin
            mm_acc = valid_i && model_ready();
            if (m_busy && m_delay == 0 && ready_i) m_busy = 1'b0;
            else if (m_busy && m_delay > 0)        m_delay = m_delay - 1;
            if (mm_acc) begin
                mm_sp   = model_spec(add1, add2, WN);
                mm_ex   = model_exact(add1, add2);
                m_busy  = 1'b1;
                m_err   = (mm_sp != mm_ex);
                m_delay = (CORR && m_err) ? 1 : 0;
                m_res   = CORR ? mm_ex : mm_sp;
                if (m_err) begin
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    if (sm_cnt < 3)    sm_cnt = sm_cnt + 1;
                end
            end
            if (clr_cnt_i) begin
                m_cnt = 0; sm_cnt = 0;
            end
            if (f_valid_i) begin
                fm_busy = 1'b1;
                fm_res  = model_exact(f_a, f_b);
                fm_err  = (model_spec(f_a, f_b, 32) != fm_res);
                if (fm_err) fm_cnt = fm_cnt + 1;
            end else begin
                fm_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("ready_o", 64'(ready_o), 64'(model_ready()));
        check("valid_o", 64'(valid_o), 64'(m_busy && m_delay == 0));
        if (m_busy && m_delay == 0) begin
            check("result_o", 64'(result_o), 64'(m_res));
            check("err_o", 64'(err_o), 64'(m_err));
            check("s_result_o", 64'(s_result_o), 64'(m_res));
            check("s_err_o", 64'(s_err_o), 64'(m_err));
        end
        if (rst) begin
            check("rst_result_o", 64'(result_o), 64'd0);
            check("rst_err_o", 64'(err_o), 64'd0);
        end
        check("err_cnt_o", 64'(err_cnt_o), 64'(m_cnt));
        check("s_ready_o", 64'(s_ready_o), 64'(model_ready()));
        check("s_valid_o", 64'(s_valid_o), 64'(m_busy && m_delay == 0));
        check("s_cnt_o", 64'(s_cnt_o), 64'(sm_cnt));
        check("f_ready_o", 64'(f_ready_o), 64'(!rst));
        check("f_valid_o", 64'(f_valid_o), 64'(fm_busy));
        if (fm_busy) begin
            check("f_result_o", 64'(f_result_o), 64'(fm_res));
            check("f_err_o", 64'(f_err_o), 64'(fm_err));
        end
        check("f_cnt_o", 64'(f_cnt_o), 64'(fm_cnt));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [32:0] res;
        logic        e;

        #1 rst = 1'b1;
        @(negedge clk);
        check("lit_rst_valid", 64'(valid_o), 64'd0);
        check("lit_rst_ready", 64'(ready_o), 64'd0);
        check("lit_rst_result", 64'(result_o), 64'd0);
        check("lit_rst_cnt", 64'(err_cnt_o), 64'd0);
        check("pin_spec_ffff", 64'(model_spec(32'h0000FFFF, 32'h1, 8)), 64'h0_0000FE00);
        check("pin_spec_ffffffff", 64'(model_spec(32'hFFFFFFFF, 32'h1, 8)), 64'h0_FFFFFE00);
        check("pin_spec_full", 64'(model_spec(32'h0000FFFF, 32'h1, 32)), 64'h0_00010000);
        @(posedge clk);
        #1 rst = 1'b0;

        xfer(32'd5, 32'd3, 1'b0, lat, res, e);
        check("lit_5p3_res", 64'(res), 64'h0_00000008);
        check("lit_5p3_err", 64'(e), 64'd0);
        check("lit_5p3_lat", 64'(lat), 64'd1);

        xfer(32'h0000FFFF, 32'h1, 1'b0, lat, res, e);
        check("lit_ffff_res", 64'(res), CORR ? 64'h0_00010000 : 64'h0_0000FE00);
        check("lit_ffff_err", 64'(e), 64'd1);
        check("lit_ffff_lat", 64'(lat), CORR ? 64'd2 : 64'd1);
        check("lit_ffff_cnt", 64'(err_cnt_o), 64'd1);

        xfer(32'hFFFFFFFF, 32'h1, 1'b0, lat, res, e);
        check("lit_wrap_res", 64'(res), CORR ? 64'h1_00000000 : 64'h0_FFFFFE00);
        check("lit_wrap_err", 64'(e), 64'd1);
        xfer(32'h12345678, 32'h11111111, 1'b0, lat, res, e);
        check("lit_mix_res", 64'(res), 64'h0_23456789);
        xfer(32'h80000000, 32'h80000000, 1'b0, lat, res, e);
        check("lit_cout_res", 64'(res), 64'h1_00000000);
        check("lit_cout_err", 64'(e), 64'd0);

        // Backpressure, then back-to-back accept as ready_i returns.
        tick();
        ready_i = 1'b0;
        xfer(32'd7, 32'd9, 1'b0, lat, res, e);
        for (int k = 0; k < 3; k++) begin
            check("lit_bp_result", 64'(result_o), 64'h10);
            check("lit_bp_ready", 64'(ready_o), 64'd0);
            check("lit_bp_valid", 64'(valid_o), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1; valid_i = 1'b1; add1 = 32'h100; add2 = 32'h200;
        @(negedge clk);
        check("lit_b2b_ready", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        check("lit_b2b_valid", 64'(valid_o), 64'd1);
        check("lit_b2b_result", 64'(result_o), 64'h300);

        // Two misses so far; three more saturate the narrow counter.
        for (int k = 0; k < 3; k++) xfer(32'h0000FFFF, 32'h1, 1'b0, lat, res, e);
        check("lit_cnt5", 64'(err_cnt_o), 64'd5);
        check("lit_small_sat", 64'(s_cnt_o), 64'd3);
        xfer(32'h0000FFFF, 32'h1, 1'b1, lat, res, e);
        check("lit_clr_cnt", 64'(err_cnt_o), 64'd0);
        check("lit_clr_small", 64'(s_cnt_o), 64'd0);
        check("lit_clr_err", 64'(e), 64'd1);

        // Reset while a missed result is in flight.
        tick();
        valid_i = 1'b1; add1 = 32'h0000FFFF; add2 = 32'h1;
        @(posedge clk);
        #1;
        valid_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("lit_mid_rst_ready", 64'(ready_o), 64'd0);
        check("lit_mid_rst_valid", 64'(valid_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("lit_post_rst_valid", 64'(valid_o), 64'd0);
        check("lit_post_rst_cnt", 64'(err_cnt_o), 64'd0);
        check("lit_post_rst_ready", 64'(ready_o), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lit_post_rst_quiet", 64'(valid_o), 64'd0);
        end

        // Full-width window: never a miss.
        tick();
        f_a = 32'h0000FFFF; f_b = 32'h1; f_valid_i = 1'b1;
        tick();
        f_a = 32'hFFFFFFFF; f_b = 32'hFFFFFFFF;
        @(negedge clk);
        check("lit_full_ffff", 64'(f_result_o), 64'h0_00010000);
        check("lit_full_err", 64'(f_err_o), 64'd0);
        tick();
        f_valid_i = 1'b0;
        @(negedge clk);
        check("lit_full_max", 64'(f_result_o), 64'h1_FFFFFFFE);
        for (int k = 0; k < 10000; k++) begin
            tick();
            f_a = $urandom(); f_b = $urandom(); f_valid_i = 1'b1;
        end
        tick();
        f_valid_i = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vl_aca_adder.md
VL_ACA_ADDER -- requirements
Module: vl_aca_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 SHALL have parameter WIN, default 8, giving the speculation window in bits; legal range 1 <= WIN <= WIDTH.
REQ-003 SHALL have parameter CNT_W, default 16, giving the error counter width.
REQ-004 SHALL use one clock and one reset: the reset is asynchronous and active-high.
REQ-005 Ports, clock and reset first:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- valid_i  in  1  operand pair valid
- ready_o  out  1  block accepts operands
- add1_i  in  WIDTH  operand A
- add2_i  in  WIDTH  operand B
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  WIDTH+1  sum, with carry-out as the MSB
- err_o  out  1  speculation missed for this result
- err_cnt_o  out  CNT_W  saturating count of misses
- clr_cnt_i  in  1  synchronous counter clear

Function
REQ-006 Speculative sum: the carry into bit i SHALL be computed from operand bits max(0,i-WIN)..i-1 only, with carry 0 entering that window; the carry-out uses bits WIDTH-WIN..WIDTH-1.
REQ-007 A miss SHALL be declared when the speculative sum (WIDTH+1 bits) differs from the exact sum.
REQ-008 Handshake SHALL be: accept when valid_i && ready_o; deliver when valid_o && ready_i.
REQ-009 ready_o SHALL equal (state==IDLE) || (state==HOLD && ready_i), and SHALL be 0 in FIX.
REQ-010 The FSM SHALL have states IDLE, HOLD and FIX with these transitions:
- IDLE --accept, no miss--> HOLD
- IDLE --accept, miss--> FIX (with ACA_ERR_CORRECT_EN defined)
- FIX --> HOLD, unconditionally after 1 cycle
- HOLD --ready_i && !accept--> IDLE
- HOLD --ready_i && accept--> HOLD or FIX, per the miss rule
REQ-011 Latency SHALL be 1 cycle from accept to valid_o on a hit and 2 cycles on a corrected miss.
REQ-012 While valid_o && !ready_i, result_o and err_o SHALL hold stable.
REQ-013 err_cnt_o SHALL increment by 1 per accepted miss and saturate at all-ones.
REQ-014 If clr_cnt_i and an increment coincide, the clear SHALL win and the counter SHALL be 0.
REQ-015 WIN==WIDTH SHALL never produce a miss.

Reset
REQ-016 While rst_i is asserted: state=IDLE, valid_o=0, result_o=0, err_o=0, err_cnt_o=0, ready_o=0.
REQ-017 Reset asserted during FIX or HOLD SHALL discard the in-flight result; no valid_o pulse SHALL follow deassertion.

Configuration
REQ-018 Macro ACA_ERR_CORRECT_EN defined: a miss SHALL enter FIX, register the operands, and deliver the exact sum with err_o=1.
REQ-019 Macro ACA_ERR_CORRECT_EN undefined: the FIX state SHALL be absent, latency SHALL always be 1, and a miss SHALL deliver the speculative sum with err_o=1. The counter SHALL still count misses.

Structure
REQ-020 Package vl_aca_pkg SHALL hold the state enum (IDLE/HOLD/FIX) and the default WIDTH/WIN/CNT_W constants.
REQ-021 Sub-module aca_spec_sum (combinational, parameters WIDTH and WIN) SHALL produce the speculative sum. Exact sum and compare logic SHALL live in vl_aca_adder.

Verification (WIDTH=32, WIN=8 unless stated)
REQ-022 0x00000005 + 0x00000003 -> result_o=0x0_00000008, err_o=0, valid_o 1 cycle after accept.
REQ-023 0x0000FFFF + 0x00000001:
- macro defined -> result_o=0x0_00010000, err_o=1, valid_o 2 cycles after accept, err_cnt_o=1.
- macro undefined -> result_o=0x0_0000FE00, err_o=1, valid_o 1 cycle after accept.
REQ-024 Backpressure: hold ready_i=0 for 3 cycles after a result -> result_o held, ready_o=0; then ready_i=1 with valid_i=1 -> next operand accepted that cycle (back-to-back).
REQ-025 CNT_W=2, five missing operations -> err_cnt_o=3; then clr_cnt_i coincident with a miss -> err_cnt_o=0.
REQ-026 rst_i pulsed during FIX -> valid_o stays 0, err_cnt_o=0, ready_o=1 the first cycle after deassertion.
REQ-027 WIN=32, 10000 random operand pairs -> err_o always 0 and result_o equals the exact sum.
